// File: rtl/wbu_pkg.sv
// Shared encodings for the buffered writeback stage: result sources and load sizes.
package wbu_pkg;

    typedef enum logic [1:0] {
        SRC_ALU = 2'd0,
        SRC_MEM = 2'd1,
        SRC_PC  = 2'd2,
        SRC_CSR = 2'd3
    } reg_wr_src_e;

    typedef enum logic [2:0] {
        LD_B   = 3'd0,
        LD_H   = 3'd1,
        LD_W   = 3'd2,
        LD_D   = 3'd3,
        LD_BU  = 3'd4,
        LD_HU  = 3'd5,
        LD_WU  = 3'd6,
        LD_RSV = 3'd7
    } ld_size_e;

    localparam int unsigned PC_STEP = 4;

    // Width of the byte-offset field taken from the ALU result for loads.
    function automatic int unsigned ld_off_w(input int unsigned data_width);
        return $clog2(data_width / 8);
    endfunction

endpackage

// File: rtl/wbu_buf_if.sv
// Bundle of the l2w result, IFU commit handshake, GPR write and forwarding signals.
interface wbu_buf_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int GPRS_WIDTH = 5,
    parameter int CNT_WIDTH  = 64
) ();
    logic                  i_l2w_valid;
    logic                  o_wbu_ready;
    logic                  o_wbu_valid;
    logic                  i_ifu_ready;
    logic                  i_l2w_ctr_reg_wr_en;
    logic [1:0]            i_l2w_ctr_reg_wr_src;
    logic [2:0]            i_l2w_ctr_ld_size;
    logic [ADDR_WIDTH-1:0] i_l2w_pc;
    logic [DATA_WIDTH-1:0] i_l2w_alu_res;
    logic [DATA_WIDTH-1:0] i_l2w_ram_res;
    logic [DATA_WIDTH-1:0] i_l2w_csr_res;
    logic [GPRS_WIDTH-1:0] i_l2w_wr_id;
    logic                  o_wbu_gpr_wr_en;
    logic [GPRS_WIDTH-1:0] o_wbu_gpr_wr_id;
    logic [DATA_WIDTH-1:0] o_wbu_gpr_wr_data;
    logic [GPRS_WIDTH-1:0] i_fwd_rs_id;
    logic                  o_fwd_hit;
    logic [DATA_WIDTH-1:0] o_fwd_data;
    logic                  o_wbu_pc_en;
    logic [CNT_WIDTH-1:0]  o_wbu_retire_cnt;

    modport slave (
        input  i_l2w_valid, i_ifu_ready, i_l2w_ctr_reg_wr_en, i_l2w_ctr_reg_wr_src,
               i_l2w_ctr_ld_size, i_l2w_pc, i_l2w_alu_res, i_l2w_ram_res,
               i_l2w_csr_res, i_l2w_wr_id, i_fwd_rs_id,
        output o_wbu_ready, o_wbu_valid, o_wbu_gpr_wr_en, o_wbu_gpr_wr_id,
               o_wbu_gpr_wr_data, o_fwd_hit, o_fwd_data, o_wbu_pc_en, o_wbu_retire_cnt
    );

    modport master (
        output i_l2w_valid, i_ifu_ready, i_l2w_ctr_reg_wr_en, i_l2w_ctr_reg_wr_src,
               i_l2w_ctr_ld_size, i_l2w_pc, i_l2w_alu_res, i_l2w_ram_res,
               i_l2w_csr_res, i_l2w_wr_id, i_fwd_rs_id,
        input  o_wbu_ready, o_wbu_valid, o_wbu_gpr_wr_en, o_wbu_gpr_wr_id,
               o_wbu_gpr_wr_data, o_fwd_hit, o_fwd_data, o_wbu_pc_en, o_wbu_retire_cnt
    );
endinterface

// File: rtl/wbu_buf_fifo.sv
// Circular buffer of opaque entries; also presents every slot in age order (oldest first)
// with a per-slot valid so the owner can search uncommitted entries.
module wbu_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [W-1:0]     wdata,
    output logic [W-1:0]     head,
    output logic             full,
    output logic             empty,
    output logic [W-1:0]     ord [DEPTH],
    output logic [DEPTH-1:0] ord_vld
);
    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [PW:0]   count;

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= wdata;
    end

    assign head  = mem[rd_ptr];
    assign full  = (count == (PW+1)'(DEPTH));
    assign empty = (count == '0);

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ord[i]     = mem[rd_ptr + PW'(i)];
            ord_vld[i] = ((PW+1)'(i) < count);
        end
    end

endmodule

// File: rtl/wbu_buf.sv
// Buffered writeback stage: forms the GPR result at accept, queues it, commits one entry
// per IFU handshake and serves forwarding lookups from uncommitted entries.
module wbu_buf
    import wbu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int GPRS_WIDTH = 5,
    parameter int DEPTH      = 2,
    parameter int CNT_WIDTH  = 64
) (
    input  logic      i_clk,
    input  logic      i_rst_n,
    wbu_buf_if.slave  bus
);
    typedef struct packed {
        logic                  wr_en;
        logic [GPRS_WIDTH-1:0] wr_id;
        logic [DATA_WIDTH-1:0] data;
    } entry_t;

    localparam int EW    = $bits(entry_t);
    localparam int OFF_W = ld_off_w(DATA_WIDTH);

    // Right-align the addressed lane, then extend per size; unsupported sizes pass the word.
    function automatic logic [DATA_WIDTH-1:0] load_ext(
        input logic [DATA_WIDTH-1:0] ram,
        input logic [OFF_W-1:0]      off,
        input logic [2:0]            size
    );
        logic [DATA_WIDTH-1:0] s;
        s = ram >> {off, 3'b000};
        case (ld_size_e'(size))
            LD_B:    return DATA_WIDTH'($signed(s[7:0]));
            LD_H:    return DATA_WIDTH'($signed(s[15:0]));
            LD_W:    return DATA_WIDTH'($signed(s[31:0]));
            LD_BU:   return DATA_WIDTH'(s[7:0]);
            LD_HU:   return DATA_WIDTH'(s[15:0]);
            LD_WU:   return DATA_WIDTH'(s[31:0]);
            default: return s;
        endcase
    endfunction

    logic             push;
    logic             pop;
    logic             full;
    logic             empty;
    entry_t           new_e;
    logic [EW-1:0]    head_raw;
    entry_t           head_e;
    logic [EW-1:0]    ord_raw [DEPTH];
    logic [DEPTH-1:0] ord_vld;
    logic [CNT_WIDTH-1:0] retire_cnt;

    always_comb begin
        new_e.wr_en = bus.i_l2w_ctr_reg_wr_en && (bus.i_l2w_wr_id != '0);
        new_e.wr_id = bus.i_l2w_wr_id;
        case (reg_wr_src_e'(bus.i_l2w_ctr_reg_wr_src))
            SRC_MEM: new_e.data = load_ext(bus.i_l2w_ram_res,
                                           bus.i_l2w_alu_res[OFF_W-1:0],
                                           bus.i_l2w_ctr_ld_size);
            SRC_PC:  new_e.data = DATA_WIDTH'(bus.i_l2w_pc + ADDR_WIDTH'(PC_STEP));
            SRC_CSR: new_e.data = bus.i_l2w_csr_res;
            default: new_e.data = bus.i_l2w_alu_res;
        endcase
    end

    // Ready depends only on the registered fill level, never on i_ifu_ready.
    assign push = bus.i_l2w_valid && !full;
    assign pop  = !empty && bus.i_ifu_ready;

    wbu_fifo #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .push    (push),
        .pop     (pop),
        .wdata   (new_e),
        .head    (head_raw),
        .full    (full),
        .empty   (empty),
        .ord     (ord_raw),
        .ord_vld (ord_vld)
    );

    assign head_e = entry_t'(head_raw);

    assign bus.o_wbu_ready       = !full;
    assign bus.o_wbu_valid       = !empty;
    assign bus.o_wbu_pc_en       = pop;
    assign bus.o_wbu_gpr_wr_en   = pop && head_e.wr_en;
    assign bus.o_wbu_gpr_wr_id   = pop ? head_e.wr_id : '0;
    assign bus.o_wbu_gpr_wr_data = pop ? head_e.data  : '0;
    assign bus.o_wbu_retire_cnt  = retire_cnt;

    // Slots are oldest-first, so the last match in the scan is the youngest producer.
    always_comb begin
        entry_t e;
        bus.o_fwd_hit  = 1'b0;
        bus.o_fwd_data = '0;
        for (int i = 0; i < DEPTH; i++) begin
            e = entry_t'(ord_raw[i]);
            if (ord_vld[i] && e.wr_en && (e.wr_id == bus.i_fwd_rs_id)
                && (bus.i_fwd_rs_id != '0)) begin
                bus.o_fwd_hit  = 1'b1;
                bus.o_fwd_data = e.data;
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            retire_cnt <= '0;
        end else if (pop) begin
            retire_cnt <= retire_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_wbu_buf.sv
// Randomized and directed bench for wbu_buf against a queue-based writeback model.
module tb_wbu_buf;
    localparam int DW = 32;
    localparam int AW = 32;
    localparam int GW = 5;
    localparam int DEPTH = 2;
    localparam int CW = 64;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    wbu_buf_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .GPRS_WIDTH(GW), .CNT_WIDTH(CW)) bus ();

    wbu_buf #(
        .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .GPRS_WIDTH(GW), .DEPTH(DEPTH), .CNT_WIDTH(CW)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    typedef struct {
        logic        en;
        logic [4:0]  id;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    logic [63:0] exp_ret;
    int          n_cmp = 0;
    int          n_err = 0;
    logic        pushed;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_res(input logic [1:0] src, input logic [2:0] size,
                                              input logic [31:0] pc, input logic [31:0] alu,
                                              input logic [31:0] ram, input logic [31:0] csr);
        logic [31:0] w;
        int          off;
        off = int'(alu[1:0]);
        w   = ram >> (8 * off);
        case (src)
            2'd0: return alu;
            2'd2: return pc + 32'd4;
            2'd3: return csr;
            default: begin
                case (size)
                    3'd0: return (w[7:0]  >= 8'h80)   ? ((w & 32'hFF)   | 32'hFFFF_FF00) : (w & 32'hFF);
                    3'd1: return (w[15:0] >= 16'h8000) ? ((w & 32'hFFFF) | 32'hFFFF_0000) : (w & 32'hFFFF);
                    3'd4: return w & 32'hFF;
                    3'd5: return w & 32'hFFFF;
                    default: return w;
                endcase
            end
        endcase
    endfunction

    // Called just after a falling edge with inputs already applied.
    task automatic step();
        logic        do_push;
        logic        do_pop;
        logic        hit;
        logic [31:0] fdata;
        ent_t        ne;
        #1;
        do_pop  = (q.size() != 0) && bus.i_ifu_ready;
        do_push = bus.i_l2w_valid && (q.size() < DEPTH);
        check("ready", 64'(bus.o_wbu_ready), 64'(q.size() < DEPTH));
        check("valid", 64'(bus.o_wbu_valid), 64'(q.size() != 0));
        check("pc_en", 64'(bus.o_wbu_pc_en), 64'(do_pop));
        check("wr_en", 64'(bus.o_wbu_gpr_wr_en), do_pop ? 64'(q[0].en) : 64'd0);
        check("wr_id", 64'(bus.o_wbu_gpr_wr_id), do_pop ? 64'(q[0].id) : 64'd0);
        check("wr_data", 64'(bus.o_wbu_gpr_wr_data), do_pop ? 64'(q[0].data) : 64'd0);
        hit = 1'b0;
        fdata = '0;
        for (int i = q.size() - 1; i >= 0; i--) begin
            if (!hit && q[i].en && q[i].id == bus.i_fwd_rs_id && bus.i_fwd_rs_id != 0) begin
                hit = 1'b1;
                fdata = q[i].data;
            end
        end
        check("fwd_hit", 64'(bus.o_fwd_hit), 64'(hit));
        check("fwd_data", 64'(bus.o_fwd_data), 64'(fdata));
        check("retire", bus.o_wbu_retire_cnt, exp_ret);
        ne.en   = bus.i_l2w_ctr_reg_wr_en && (bus.i_l2w_wr_id != 0);
        ne.id   = bus.i_l2w_wr_id;
        ne.data = model_res(bus.i_l2w_ctr_reg_wr_src, bus.i_l2w_ctr_ld_size, bus.i_l2w_pc,
                            bus.i_l2w_alu_res, bus.i_l2w_ram_res, bus.i_l2w_csr_res);
        @(posedge clk);
        if (do_pop) begin
            void'(q.pop_front());
            exp_ret++;
        end
        if (do_push) q.push_back(ne);
        pushed = do_push;
        @(negedge clk);
    endtask

    task automatic set_in(input logic v, input logic [1:0] src, input logic [2:0] size,
                          input logic [31:0] pc, input logic [31:0] alu, input logic [31:0] ram,
                          input logic [31:0] csr, input logic [4:0] id, input logic wen);
        bus.i_l2w_valid          = v;
        bus.i_l2w_ctr_reg_wr_src = src;
        bus.i_l2w_ctr_ld_size    = size;
        bus.i_l2w_pc             = pc;
        bus.i_l2w_alu_res        = alu;
        bus.i_l2w_ram_res        = ram;
        bus.i_l2w_csr_res        = csr;
        bus.i_l2w_wr_id          = id;
        bus.i_l2w_ctr_reg_wr_en  = wen;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        q.delete();
        exp_ret = '0;
        #1;
        check("rst_ready", 64'(bus.o_wbu_ready), 64'd1);
        check("rst_valid", 64'(bus.o_wbu_valid), 64'd0);
        check("rst_wr_en", 64'(bus.o_wbu_gpr_wr_en), 64'd0);
        check("rst_pc_en", 64'(bus.o_wbu_pc_en), 64'd0);
        check("rst_fwd", 64'(bus.o_fwd_hit), 64'd0);
        check("rst_retire", bus.o_wbu_retire_cnt, 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        int guard;
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.i_ifu_ready = 1'b1;
        bus.i_fwd_rs_id = 5'd7;
        @(negedge clk);
        do_reset();

        // Loads, PC+4, CSR and x0 suppression with an always-ready IFU.
        set_in(1, 1, 0, 0, 32'h1003, 32'h80FF_0000, 0, 5, 1); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("ldb_data", 64'(bus.o_wbu_gpr_wr_data), 64'hFFFF_FF80);
        check("ldb_id", 64'(bus.o_wbu_gpr_wr_id), 64'd5);
        step();
        set_in(1, 1, 4, 0, 32'h1003, 32'h80FF_0000, 0, 5, 1); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("ldbu_data", 64'(bus.o_wbu_gpr_wr_data), 64'h0000_0080);
        step();
        set_in(1, 1, 1, 0, 32'h1002, 32'h80FF_0000, 0, 5, 1); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("ldh_data", 64'(bus.o_wbu_gpr_wr_data), 64'hFFFF_80FF);
        step();
        set_in(1, 2, 0, 32'h8000_0010, 0, 0, 0, 1, 1); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("pc4_data", 64'(bus.o_wbu_gpr_wr_data), 64'h8000_0014);
        check("pc4_pc_en", 64'(bus.o_wbu_pc_en), 64'd1);
        step();
        check("pc_en_idle", 64'(bus.o_wbu_pc_en), 64'd0);
        set_in(1, 3, 0, 0, 0, 0, 32'h1234, 9, 1); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("csr_data", 64'(bus.o_wbu_gpr_wr_data), 64'h1234);
        step();
        set_in(1, 0, 0, 0, 32'hDEAD, 0, 0, 0, 1); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        check("x0_wr_en", 64'(bus.o_wbu_gpr_wr_en), 64'd0);
        check("x0_pc_en", 64'(bus.o_wbu_pc_en), 64'd1);
        step();

        // Back-pressure: fill, hold a third result, then drain in order.
        do_reset();
        bus.i_ifu_ready = 1'b0;
        set_in(1, 0, 0, 0, 32'hA, 0, 0, 10, 1); step();
        set_in(1, 0, 0, 0, 32'hB, 0, 0, 11, 1); step();
        set_in(1, 0, 0, 0, 32'hC, 0, 0, 12, 1);
        check("full_ready", 64'(bus.o_wbu_ready), 64'd0);
        step();
        bus.i_ifu_ready = 1'b1;
        guard = 0;
        pushed = 1'b0;
        while (!pushed && guard < 6) begin step(); guard++; end
        check("third_accepted", 64'(pushed), 64'd1);
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        guard = 0;
        while (q.size() != 0 && guard < 6) begin step(); guard++; end
        check("drained", 64'(q.size()), 64'd0);
        check("retire3", bus.o_wbu_retire_cnt, 64'd3);

        // Forwarding picks the youngest producer.
        bus.i_ifu_ready = 1'b0;
        set_in(1, 0, 0, 0, 32'h11, 0, 0, 7, 1); step();
        set_in(1, 0, 0, 0, 32'h22, 0, 0, 7, 1); step();
        set_in(0, 0, 0, 0, 0, 0, 0, 0, 0);
        bus.i_fwd_rs_id = 5'd7;
        #1;
        check("fwd7_hit", 64'(bus.o_fwd_hit), 64'd1);
        check("fwd7_data", 64'(bus.o_fwd_data), 64'h22);
        step();
        bus.i_fwd_rs_id = 5'd8; step();
        bus.i_fwd_rs_id = 5'd0; step();

        // Reset with two entries in flight discards them.
        bus.i_ifu_ready = 1'b1;
        do_reset();
        step();

        for (int n = 0; n < 1000; n++) begin
            logic [2:0] sz;
            case ($urandom_range(0, 4))
                0: sz = 3'd0;
                1: sz = 3'd1;
                2: sz = 3'd2;
                3: sz = 3'd4;
                default: sz = 3'd5;
            endcase
            set_in($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), sz, $urandom,
                   $urandom, $urandom, $urandom, 5'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
            bus.i_ifu_ready = $urandom_range(0, 2) != 0;
            bus.i_fwd_rs_id = 5'($urandom_range(0, 7));
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
